regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port general-purpose register file for the pipelined MIPS32 core.
//  Provides NUM_RD combinational read ports with write-to-read bypass and NUM_WR write ports.
//  Includes a per-register pending-write scoreboard for hazard detection and a registered debug read port.
//  Sits between decode (reads, busy queries) and writeback (writes, busy clears).
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width; depth = 2**ADDR_W
//  NUM_RD    2   read ports, legal range 1..4
//  NUM_WR    2   write ports, legal range 1..2; a higher index has priority
//  ZERO_REG  1   1: register 0 reads as 0, ignores writes, is never busy; 0: register 0 is ordinary
// PORTS
//  clk              in   1               clock; all state updates on posedge
//  rst              in   1               reset, synchronous, active-low
//  rd_en_i          in   NUM_RD          per-port read enable
//  rd_addr_i        in   NUM_RD*ADDR_W   packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//  rd_data_o        out  NUM_RD*DATA_W   packed read data, combinational
//  rd_busy_o        out  NUM_RD          read target has an outstanding producer, combinational
//  wr_en_i          in   NUM_WR          per-port write enable
//  wr_addr_i        in   NUM_WR*ADDR_W   packed write addresses
//  wr_data_i        in   NUM_WR*DATA_W   packed write data
//  busy_set_i       in   1               issue of an instruction that writes busy_addr_i
//  busy_addr_i      in   ADDR_W          destination register marked pending
//  dbg_addr_i       in   ADDR_W          debug read address
//  dbg_data_o       out  DATA_W          registered debug read data
// BEHAVIOUR
//  Reset (rst==0 at posedge)
//   - All registers are cleared to 0, all busy bits are cleared, and dbg_data_o becomes 0.
//   - While rst==0, rd_data_o and rd_busy_o are forced to 0.
//  Write (posedge, rst==1)
//   - Port w writes when wr_en_i[w]==1.
//   - If both ports target the same address, port NUM_WR-1 wins.
//   - A write to address 0 is dropped when ZERO_REG=1.
//  Read (combinational), per port p, first match wins:
//   - rst==0 -> 0
//   - rd_en_i[p]==0 -> 0
//   - addr==0 && ZERO_REG -> 0
//   - match on an enabled write port -> that port's wr_data_i; the highest-index matching port is used
//   - otherwise -> array[addr]
//  Scoreboard
//   - busy[a] is cleared at posedge by any enabled write to a.
//   - busy[a] is set at posedge by busy_set_i with busy_addr_i==a.
//   - If a set and a clear hit the same address in one cycle, the set wins (a newer producer was issued).
//   - busy_set_i to address 0 is ignored when ZERO_REG=1.
//   - rd_busy_o[p] = rst & rd_en_i[p] & busy[addr] & ~(enabled write to addr this cycle).
//     The bypass supplies the value, so no stall is needed.
//  Debug port
//   - Latency 1: dbg_data_o <= array[dbg_addr_i], sampled before the same-edge write.
//   - No bypass; address 0 returns 0 when ZERO_REG=1.
//  Arithmetic: none; all address compares are ADDR_W-bit equality.
// STRUCTURE
//  - cpu_pkg / cpu_defines holds DATA_W_DEF=32, ADDR_W_DEF=5, and REG_ZERO=5'd0, shared with decode and writeback.
//  - Sub-module regfile_rd_port is instantiated NUM_RD times in a generate loop.
//    It contains the enable/zero/bypass priority mux and the busy qualification.
//  - Storage array, write logic, scoreboard and debug register are in the top module.
// TESTING
//  1. Hold rst=0 for 1 clk after random writes.
//     -> all 32 regs read 0 via the debug port; rd_busy_o=0.
//  2. Write port0 r5=0x1234_5678 while port1 writes r5=0xDEAD_BEEF in the same cycle.
//     -> next cycle read r5 = 0xDEAD_BEEF; same cycle, the bypass also returns 0xDEAD_BEEF.
//  3. Write r0=0xFFFF_FFFF with busy_set_i to r0 (ZERO_REG=1).
//     -> reads of r0 = 0; rd_busy_o = 0.
//  4. busy_set r7, then 3 idle clk.
//     -> rd_busy=1 on reads of r7.
//     Then write r7=0xA5.
//     -> same cycle rd_busy=0 and rd_data=0xA5; next cycle busy stays clear.
//  5. Same cycle: write r9 and busy_set r9.
//     -> next cycle busy[r9]=1 and r9 holds the new data.
//  6. Write r3=0x77 while dbg_addr_i=3.
//     -> dbg_data_o shows the old r3 next cycle and 0x77 one cycle later; NUM_RD=4 regression with all ports on r3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: default register-file geometry, the hard-wired zero
// register index and the read-port source selector.
package cpu_pkg;

  localparam int         DATA_W_DEF = 32;
  localparam int         ADDR_W_DEF = 5;
  localparam logic [4:0] REG_ZERO   = 5'd0;

  // Where a read port takes its value from, in priority order.
  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ARRAY  = 2'd2
  } rd_src_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: enable/zero/bypass priority mux plus busy
// qualification against same-cycle writes.
module regfile_rd_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     rst,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]        array_data,
  input  logic                     busy,
  output logic [DATA_W-1:0]        data,
  output logic                     busy_out
);

  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              is_zero;
  rd_src_e           src;

  assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    // Ascending scan: the highest-index matching write port overrides.
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == addr)) begin
        hit      = 1'b1;
        hit_data = wr_data[w*DATA_W +: DATA_W];
      end
    end

    if (!rst || !en || is_zero) src = SRC_ZERO;
    else if (hit)               src = SRC_BYPASS;
    else                        src = SRC_ARRAY;
  end

  always_comb begin
    case (src)
      SRC_ZERO:   data = '0;
      SRC_BYPASS: data = hit_data;
      default:    data = array_data;
    endcase
  end

  // A same-cycle write supplies the value through the bypass, so no stall.
  assign busy_out = rst & en & busy & ~hit;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port MIPS32 register file with write-to-read bypass, pending-write
// scoreboard and a registered debug read port.
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     busy_set_i,
  input  logic [ADDR_W-1:0]        busy_addr_i,
  input  logic [ADDR_W-1:0]        dbg_addr_i,
  output logic [DATA_W-1:0]        dbg_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_W'(REG_ZERO));
  endfunction

  // NOTE: the storage array is reset element by element because the core
  // relies on every register starting at zero; this keeps it in flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy       <= '0;
      dbg_data_o <= '0;
    end else begin
      // Reads the pre-edge array contents: no bypass on the debug path.
      dbg_data_o <= is_zero_addr(dbg_addr_i) ? '0 : regs[dbg_addr_i];

      // NOTE: non-blocking assignments in program order; the last one to a
      // target wins, which gives the higher write port priority and lets a
      // busy set override a same-cycle clear.
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en_i[w]) begin
          if (!is_zero_addr(wr_addr_i[w*ADDR_W +: ADDR_W]))
            regs[wr_addr_i[w*ADDR_W +: ADDR_W]] <= wr_data_i[w*DATA_W +: DATA_W];
          busy[wr_addr_i[w*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end

      if (busy_set_i && !is_zero_addr(busy_addr_i))
        busy[busy_addr_i] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .rst       (rst),
      .en        (rd_en_i[p]),
      .addr      (rd_addr_i[p*ADDR_W +: ADDR_W]),
      .wr_en     (wr_en_i),
      .wr_addr   (wr_addr_i),
      .wr_data   (wr_data_i),
      .array_data(regs[rd_addr_i[p*ADDR_W +: ADDR_W]]),
      .busy      (busy[rd_addr_i[p*ADDR_W +: ADDR_W]]),
      .data      (rd_data_o[p*DATA_W +: DATA_W]),
      .busy_out  (rd_busy_o[p])
    );
  end

endmodule
